// File: rtl/fu_csr_q_if.sv
// fu_csr_q_if: bundle of every fu_csr_q signal except clk/rstn.
//   Op request   : in_valid, in_ready, in_op, in_id, in_prd, in_addr, in_wdata, cur_priv
//   Result       : out_valid, out_id, out_prd, out_rdata, out_exc
//   Retire/flush : retire_valid, retire_id, flush
//   CSR file     : csr_raddr, csr_rdata, csr_wvalid, csr_waddr, csr_wdata
// slave is the CSR unit's view, master is the view of whoever drives it.
interface fu_csr_q_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ID_W  = 6,
    parameter int unsigned PRD_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [ID_W-1:0]  in_id;
    logic [PRD_W-1:0] in_prd;
    logic [11:0]      in_addr;
    logic [XLEN-1:0]  in_wdata;
    logic [1:0]       cur_priv;

    logic             out_valid;
    logic [ID_W-1:0]  out_id;
    logic [PRD_W-1:0] out_prd;
    logic [XLEN-1:0]  out_rdata;
    logic             out_exc;

    logic             retire_valid;
    logic [ID_W-1:0]  retire_id;
    logic             flush;

    logic [11:0]      csr_raddr;
    logic [XLEN-1:0]  csr_rdata;
    logic             csr_wvalid;
    logic [11:0]      csr_waddr;
    logic [XLEN-1:0]  csr_wdata;

    modport slave (
        input  in_valid, in_op, in_id, in_prd, in_addr, in_wdata, cur_priv,
        input  retire_valid, retire_id, flush, csr_rdata,
        output in_ready, out_valid, out_id, out_prd, out_rdata, out_exc,
        output csr_raddr, csr_wvalid, csr_waddr, csr_wdata
    );

    modport master (
        output in_valid, in_op, in_id, in_prd, in_addr, in_wdata, cur_priv,
        output retire_valid, retire_id, flush, csr_rdata,
        input  in_ready, out_valid, out_id, out_prd, out_rdata, out_exc,
        input  csr_raddr, csr_wvalid, csr_waddr, csr_wdata
    );
endinterface

// File: rtl/fu_csr_q.sv
// fu_csr_q: CSR functional unit with a DEPTH-entry in-order pending write queue.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : fu_csr_q_if.slave (op request, result, retire/flush, CSR file port)
// Ops return the old CSR value one cycle after accept. CSR writes are held in the
// queue until their ROB id retires, then committed to the CSR file in order.
// Later ops see pending writes via forwarding (FWD_EN=1) or stall on a hit (FWD_EN=0).
module fu_csr_q #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ID_W   = 6,
    parameter int unsigned PRD_W  = 7,
    parameter int unsigned DEPTH  = 4,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    fu_csr_q_if.slave    bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    // Queue storage and pointers
    logic [ID_W-1:0]  q_id   [DEPTH];
    logic [11:0]      q_addr [DEPTH];
    logic [XLEN-1:0]  q_data [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] head_nxt, tail_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic             need_write;
    logic             illegal;
    logic             hit;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  new_data;
    logic             pop;
    logic             accept;
    logic             enq;

    // Decode, privilege / read-only check
    always_comb begin
        need_write = (bus.in_op != OP_READ);
        illegal    = (bus.in_addr[9:8] > bus.cur_priv) ||
                     (need_write && (bus.in_addr[11:10] == 2'b11));
    end

    // Youngest pending write to in_addr wins; scan oldest to youngest, last match kept
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot = '0;
        hit  = 1'b0;
        base = bus.csr_rdata;
        for (int k = 0; k < int'(DEPTH); k++) begin
            slot = PTR_W'((int'(head) + k) % int'(DEPTH));
            if ((CNT_W'(k) < count) && (q_addr[slot] == bus.in_addr)) begin
                hit  = 1'b1;
                base = q_data[slot];
            end
        end
    end

    // New CSR value for write-type ops
    always_comb begin
        new_data = base;
        case (bus.in_op)
            OP_WRITE: new_data = bus.in_wdata;
            OP_SET:   new_data = base | bus.in_wdata;
            OP_CLEAR: new_data = base & ~bus.in_wdata;
            default:  new_data = base;
        endcase
    end

    // Handshake, retire pop and enqueue qualification
    always_comb begin
        pop = bus.retire_valid && (count != '0) && (q_id[head] == bus.retire_id);
        bus.in_ready = !bus.flush
                     && !(need_write && (count == CNT_W'(DEPTH)) && !pop)
                     && !(!FWD_EN && hit);
        accept = bus.in_valid && bus.in_ready;
        enq    = accept && !illegal && need_write;
    end

    // CSR file ports: read is a pass-through, write is the head entry on pop
    always_comb begin
        bus.csr_raddr  = bus.in_addr;
        bus.csr_wvalid = pop;
        bus.csr_waddr  = q_addr[head];
        bus.csr_wdata  = q_data[head];
    end

    // Next pointer / count values
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (pop) begin
            head_nxt = (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
        end
        if (enq) begin
            tail_nxt = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);
        end
        case ({enq, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        // Flush discards everything still pending; a same-cycle pop has already committed
        if (bus.flush) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end
    end

    // Queue state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                q_id[k]   <= '0;
                q_addr[k] <= '0;
                q_data[k] <= '0;
            end
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            if (enq) begin
                q_id[tail]   <= bus.in_id;
                q_addr[tail] <= bus.in_addr;
                q_data[tail] <= new_data;
            end
        end
    end

    // Result register, one cycle after accept
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.out_valid <= 1'b0;
            bus.out_id    <= '0;
            bus.out_prd   <= '0;
            bus.out_rdata <= '0;
            bus.out_exc   <= 1'b0;
        end else begin
            bus.out_valid <= accept;
            bus.out_exc   <= accept && illegal;
            if (accept) begin
                bus.out_id    <= bus.in_id;
                bus.out_prd   <= bus.in_prd;
                bus.out_rdata <= illegal ? '0 : base;
            end
        end
    end
endmodule

// File: tb/tb_fu_csr_q.sv
// tb_fu_csr_q: directed bench for fu_csr_q (DEPTH=4) with a forwarding instance
// and a stall-on-hit (FWD_EN=0) instance.
module tb_fu_csr_q;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    fu_csr_q_if #(.XLEN(64), .ID_W(6), .PRD_W(7)) bus ();
    fu_csr_q_if #(.XLEN(64), .ID_W(6), .PRD_W(7)) bus_nf ();

    fu_csr_q #(.XLEN(64), .ID_W(6), .PRD_W(7), .DEPTH(4), .FWD_EN(1'b1)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    fu_csr_q #(.XLEN(64), .ID_W(6), .PRD_W(7), .DEPTH(4), .FWD_EN(1'b0)) u_dut_nf (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input logic [1:0] op, input logic [5:0] id, input logic [11:0] addr,
                          input logic [63:0] wd);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_id = id; bus.in_prd = 7'(id + 6'd1);
        bus.in_addr = addr; bus.in_wdata = wd;
    endtask

    task automatic set_op_nf(input logic [1:0] op, input logic [5:0] id, input logic [11:0] addr,
                             input logic [63:0] wd);
        bus_nf.in_valid = 1'b1; bus_nf.in_op = op; bus_nf.in_id = id; bus_nf.in_prd = 7'(id);
        bus_nf.in_addr = addr; bus_nf.in_wdata = wd;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.retire_valid = 1'b0; bus.flush = 1'b0;
        bus_nf.in_valid = 1'b0; bus_nf.retire_valid = 1'b0; bus_nf.flush = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        bus.retire_valid = 1'b1; bus.retire_id = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_exc !== 1'b0) begin errors++; $display("FAIL rst_out_exc got %b exp 0", bus.out_exc); end
        checks++; if (bus.out_rdata !== 64'h0) begin errors++; $display("FAIL rst_out_rdata got %h exp 0", bus.out_rdata); end
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL rst_csr_wvalid got %b exp 0", bus.csr_wvalid); end
        checks++; if (bus_nf.out_valid !== 1'b0) begin errors++; $display("FAIL rst_nf_out_valid got %b exp 0", bus_nf.out_valid); end
        @(negedge clk);
        rstn = 1'b1;
        idle();
    endtask

    task automatic test_read();
        @(negedge clk);
        bus.cur_priv = 2'd3; bus.csr_rdata = 64'h8;
        set_op(RD, 6'd1, 12'h300, 64'h0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL read_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.csr_raddr !== 12'h300) begin errors++; $display("FAIL read_raddr got %h exp 300", bus.csr_raddr); end
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL read_wvalid got %b exp 0", bus.csr_wvalid); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL read_out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_rdata !== 64'h8) begin errors++; $display("FAIL read_rdata got %h exp 8", bus.out_rdata); end
        checks++; if (bus.out_exc !== 1'b0) begin errors++; $display("FAIL read_exc got %b exp 0", bus.out_exc); end
        checks++; if (bus.out_id !== 6'd1) begin errors++; $display("FAIL read_id got %0d exp 1", bus.out_id); end
        checks++; if (bus.out_prd !== 7'd2) begin errors++; $display("FAIL read_prd got %0d exp 2", bus.out_prd); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        bus.csr_rdata = 64'h11;
        set_op(WR, 6'd3, 12'h340, 64'hAA);
        @(posedge clk); #1;
        checks++; if (bus.out_rdata !== 64'h11) begin errors++; $display("FAIL fwd_write_old got %h exp 11", bus.out_rdata); end
        @(negedge clk);
        set_op(ST, 6'd4, 12'h340, 64'h05);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fwd_set_ready got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_rdata !== 64'hAA) begin errors++; $display("FAIL fwd_set_old got %h exp aa", bus.out_rdata); end
        @(negedge clk);
        set_op(CL, 6'd6, 12'h340, 64'h0F);
        @(posedge clk); #1;
        checks++; if (bus.out_rdata !== 64'hAF) begin errors++; $display("FAIL fwd_clear_old got %h exp af", bus.out_rdata); end
        @(negedge clk);
        set_op(RD, 6'd7, 12'h340, 64'h0);
        @(posedge clk); #1;
        checks++; if (bus.out_rdata !== 64'hA0) begin errors++; $display("FAIL fwd_youngest got %h exp a0", bus.out_rdata); end
        @(negedge clk);
        idle();
        bus.retire_valid = 1'b1; bus.retire_id = 6'd9;
        #1;
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL fwd_wrong_id got %b exp 0", bus.csr_wvalid); end
        @(negedge clk);
        bus.retire_id = 6'd3;
        #1;
        checks++; if (bus.csr_wvalid !== 1'b1) begin errors++; $display("FAIL fwd_ret3_wvalid got %b exp 1", bus.csr_wvalid); end
        checks++; if (bus.csr_waddr !== 12'h340) begin errors++; $display("FAIL fwd_ret3_waddr got %h exp 340", bus.csr_waddr); end
        checks++; if (bus.csr_wdata !== 64'hAA) begin errors++; $display("FAIL fwd_ret3_wdata got %h exp aa", bus.csr_wdata); end
        @(negedge clk);
        bus.retire_id = 6'd4;
        #1;
        checks++; if (bus.csr_wdata !== 64'hAF || bus.csr_wvalid !== 1'b1) begin errors++; $display("FAIL fwd_ret4 got %b/%h exp 1/af", bus.csr_wvalid, bus.csr_wdata); end
        @(negedge clk);
        bus.retire_id = 6'd6;
        #1;
        checks++; if (bus.csr_wdata !== 64'hA0 || bus.csr_wvalid !== 1'b1) begin errors++; $display("FAIL fwd_ret6 got %b/%h exp 1/a0", bus.csr_wvalid, bus.csr_wdata); end
        @(negedge clk);
        #1;
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL fwd_empty_wvalid got %b exp 0", bus.csr_wvalid); end
        idle();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        bus.cur_priv = 2'd0; bus.csr_rdata = 64'h55;
        set_op(RD, 6'd8, 12'h300, 64'h0);
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_exc !== 1'b1) begin errors++; $display("FAIL ill_priv got v%b e%b exp v1 e1", bus.out_valid, bus.out_exc); end
        checks++; if (bus.out_rdata !== 64'h0) begin errors++; $display("FAIL ill_priv_rdata got %h exp 0", bus.out_rdata); end
        @(negedge clk);
        bus.cur_priv = 2'd3;
        set_op(WR, 6'd9, 12'hC00, 64'h1);
        @(posedge clk); #1;
        checks++; if (bus.out_exc !== 1'b1 || bus.out_rdata !== 64'h0) begin errors++; $display("FAIL ill_ro got e%b %h exp e1 0", bus.out_exc, bus.out_rdata); end
        @(negedge clk);
        bus.csr_rdata = 64'h33;
        set_op(RD, 6'd10, 12'hC00, 64'h0);
        @(posedge clk); #1;
        checks++; if (bus.out_exc !== 1'b0 || bus.out_rdata !== 64'h33) begin errors++; $display("FAIL ro_read got e%b %h exp e0 33", bus.out_exc, bus.out_rdata); end
        @(negedge clk);
        idle();
        bus.retire_valid = 1'b1; bus.retire_id = 6'd9;
        #1;
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL ill_no_enq got %b exp 0", bus.csr_wvalid); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full_wrap();
        bus.csr_rdata = 64'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_op(WR, 6'(10 + i), 12'(12'h340 + i), 64'(64'h100 + i));
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, bus.in_ready); end
        end
        @(negedge clk);
        set_op(WR, 6'd14, 12'h344, 64'h104);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.in_ready); end
        bus.retire_valid = 1'b1; bus.retire_id = 6'd10;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.csr_wvalid !== 1'b1 || bus.csr_wdata !== 64'h100) begin errors++; $display("FAIL full_pop got %b/%h exp 1/100", bus.csr_wvalid, bus.csr_wdata); end
        for (int i = 5; i < 8; i++) begin
            @(negedge clk);
            set_op(WR, 6'(10 + i), 12'(12'h340 + i), 64'(64'h100 + i));
            bus.retire_id = 6'(10 + i - 4);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_%0d got %b exp 1", i, bus.in_ready); end
            checks++; if (bus.csr_wdata !== 64'(64'h100 + i - 4)) begin errors++; $display("FAIL swap_wdata_%0d got %h exp %h", i, bus.csr_wdata, 64'(64'h100 + i - 4)); end
        end
        @(negedge clk);
        set_op(WR, 6'd30, 12'h350, 64'h0);
        bus.retire_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL still_full got %b exp 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            bus.retire_valid = 1'b1; bus.retire_id = 6'(10 + i);
            #1;
            checks++; if (bus.csr_wvalid !== 1'b1 || bus.csr_waddr !== 12'(12'h340 + i) || bus.csr_wdata !== 64'(64'h100 + i))
                begin errors++; $display("FAIL drain_%0d got %b %h %h exp 1 %h %h", i, bus.csr_wvalid, bus.csr_waddr, bus.csr_wdata, 12'(12'h340 + i), 64'(64'h100 + i)); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL drained_wvalid got %b exp 0", bus.csr_wvalid); end
        idle();
    endtask

    task automatic test_flush();
        bus.csr_rdata = 64'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_op(WR, 6'(20 + i), 12'(12'h360 + i), 64'(64'h200 + i));
        end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b exp 1", bus.out_valid); end
        @(negedge clk);
        set_op(RD, 6'd25, 12'h361, 64'h0);
        bus.flush = 1'b1; bus.retire_valid = 1'b1; bus.retire_id = 6'd20;
        #1;
        checks++; if (bus.csr_wvalid !== 1'b1 || bus.csr_wdata !== 64'h200) begin errors++; $display("FAIL flush_pop got %b/%h exp 1/200", bus.csr_wvalid, bus.csr_wdata); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
        @(negedge clk);
        idle();
        bus.retire_valid = 1'b1; bus.retire_id = 6'd21;
        #1;
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL flush_ret21 got %b exp 0", bus.csr_wvalid); end
        @(negedge clk);
        bus.retire_id = 6'd22;
        #1;
        checks++; if (bus.csr_wvalid !== 1'b0) begin errors++; $display("FAIL flush_ret22 got %b exp 0", bus.csr_wvalid); end
        @(negedge clk);
        idle();
        set_op(RD, 6'd26, 12'h362, 64'h0);
        @(posedge clk); #1;
        checks++; if (bus.out_rdata !== 64'h77) begin errors++; $display("FAIL flush_no_fwd got %h exp 77", bus.out_rdata); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_no_fwd();
        @(negedge clk);
        bus_nf.cur_priv = 2'd3; bus_nf.csr_rdata = 64'h44;
        set_op_nf(WR, 6'd3, 12'h340, 64'hAA);
        #1;
        checks++; if (bus_nf.in_ready !== 1'b1) begin errors++; $display("FAIL nf_write_ready got %b exp 1", bus_nf.in_ready); end
        @(negedge clk);
        set_op_nf(RD, 6'd4, 12'h340, 64'h0);
        #1;
        checks++; if (bus_nf.in_ready !== 1'b0) begin errors++; $display("FAIL nf_hit_stall got %b exp 0", bus_nf.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_nf.out_valid !== 1'b0) begin errors++; $display("FAIL nf_stall_valid got %b exp 0", bus_nf.out_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus_nf.in_ready !== 1'b0) begin errors++; $display("FAIL nf_hit_stall2 got %b exp 0", bus_nf.in_ready); end
        set_op_nf(RD, 6'd5, 12'h341, 64'h0);
        #1;
        checks++; if (bus_nf.in_ready !== 1'b1) begin errors++; $display("FAIL nf_miss_ready got %b exp 1", bus_nf.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_nf.out_valid !== 1'b1 || bus_nf.out_id !== 6'd5 || bus_nf.out_rdata !== 64'h44)
            begin errors++; $display("FAIL nf_miss_out got v%b id%0d %h exp v1 id5 44", bus_nf.out_valid, bus_nf.out_id, bus_nf.out_rdata); end
        @(negedge clk);
        set_op_nf(RD, 6'd6, 12'h340, 64'h0);
        bus_nf.retire_valid = 1'b1; bus_nf.retire_id = 6'd3;
        #1;
        checks++; if (bus_nf.in_ready !== 1'b0) begin errors++; $display("FAIL nf_pop_cycle_ready got %b exp 0", bus_nf.in_ready); end
        checks++; if (bus_nf.csr_wvalid !== 1'b1 || bus_nf.csr_wdata !== 64'hAA) begin errors++; $display("FAIL nf_pop got %b/%h exp 1/aa", bus_nf.csr_wvalid, bus_nf.csr_wdata); end
        @(negedge clk);
        bus_nf.retire_valid = 1'b0;
        #1;
        checks++; if (bus_nf.in_ready !== 1'b1) begin errors++; $display("FAIL nf_after_pop_ready got %b exp 1", bus_nf.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_nf.out_valid !== 1'b1 || bus_nf.out_id !== 6'd6 || bus_nf.out_rdata !== 64'h44)
            begin errors++; $display("FAIL nf_after_pop_out got v%b id%0d %h exp v1 id6 44", bus_nf.out_valid, bus_nf.out_id, bus_nf.out_rdata); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = RD; bus.in_id = '0; bus.in_prd = '0;
        bus.in_addr = '0; bus.in_wdata = '0; bus.cur_priv = 2'd3;
        bus.retire_valid = 1'b0; bus.retire_id = '0; bus.flush = 1'b0; bus.csr_rdata = '0;
        bus_nf.in_valid = 1'b0; bus_nf.in_op = RD; bus_nf.in_id = '0; bus_nf.in_prd = '0;
        bus_nf.in_addr = '0; bus_nf.in_wdata = '0; bus_nf.cur_priv = 2'd3;
        bus_nf.retire_valid = 1'b0; bus_nf.retire_id = '0; bus_nf.flush = 1'b0; bus_nf.csr_rdata = '0;

        test_reset();
        test_read();
        test_forward();
        test_illegal();
        test_full_wrap();
        test_flush();
        test_no_fwd();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fu_csr_q.md
Name: fu_csr_q

Overview:
Parametrised CSR functional unit with a DEPTH-entry in-order write queue.
- Performs CSR read/write/set/clear and returns the old value to the register file one cycle after accept.
- Holds CSR writes until the owning instruction retires, then writes the CSR file in program order.
- Forwards pending writes to later CSR ops instead of stalling on read-after-write; checks privilege and read-only violations; supports pipeline flush.

Parameters:
XLEN, 64, data width
ID_W, 6, ROB id width
PRD_W, 7, physical destination register index width
DEPTH, 4, pending write queue entries (>=1)
FWD_EN, 1, 1: forward from queue on address hit; 0: stall on address hit

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
in_valid  in  1  op presented
in_ready  out  1  op accepted when in_valid&&in_ready
in_op  in  2  0 READ, 1 WRITE, 2 SET, 3 CLEAR
in_id  in  ID_W  ROB id
in_prd  in  PRD_W  destination preg
in_addr  in  12  CSR address
in_wdata  in  XLEN  rs1 / immediate operand
cur_priv  in  2  current privilege (0 U, 1 S, 3 M)
out_valid  out  1  result valid
out_id  out  ID_W  ROB id of result
out_prd  out  PRD_W  destination preg
out_rdata  out  XLEN  old CSR value
out_exc  out  1  illegal-instruction flag
retire_valid  in  1  ROB retiring an entry
retire_id  in  ID_W  retiring ROB id
flush  in  1  squash all speculative state
csr_raddr  out  12  CSR file read address (combinational = in_addr)
csr_rdata  in  XLEN  CSR file read data (combinational)
csr_wvalid  out  1  CSR file write strobe
csr_waddr  out  12  write address
csr_wdata  out  XLEN  write data

Behaviour:
- Reset: queue empty (count 0, head/tail 0), out_valid 0, out_exc 0, out_rdata 0, csr_wvalid 0.
- Queue: circular, head/tail mod DEPTH plus count 0..DEPTH; entry = {id, addr, data}.
- need_write = in_op != READ.
- Illegal when in_addr[9:8] > cur_priv, or need_write && in_addr[11:10] == 2'b11.
- base value: youngest queue entry with addr == in_addr (hit), else csr_rdata.
- Write data:
  - WRITE: in_wdata.
  - SET: base | in_wdata.
  - CLEAR: base & ~in_wdata.
- pop = retire_valid && count != 0 && head.id == retire_id. Only head is compared; retire is in order.
- in_ready = !flush && !(need_write && count == DEPTH && !pop) && !(FWD_EN == 0 && hit).
  - Illegal ops still need ready.
  - Illegal ops never enqueue.
- Accept (legal && need_write): enqueue at tail.
  - Same-cycle enqueue+pop allowed: count unchanged, works when full.
- On pop: csr_wvalid = 1 and csr_waddr/csr_wdata = head entry in the same cycle (combinational); head advances.
- Output register, latency 1:
  - Cycle after accept: out_valid = 1, with in_id, in_prd.
  - out_rdata = base, or 0 if illegal.
  - out_exc = illegal.
  - out_valid is otherwise 0.
- FWD_EN = 0: any address hit holds in_ready low until the matching entry pops.
- flush:
  - The same-cycle pop still writes the CSR (retire is architectural).
  - Then the queue is emptied, out_valid cleared next cycle, and no accept occurs that cycle.
- Wrap-around: head/tail wrap DEPTH-1 -> 0; count is the sole full/empty indicator.
- Multiple matching entries: the youngest (closest to tail) wins.

Test Plan:
- Reset, then READ addr 0x300, csr_rdata = 0x8 -> next cycle out_valid = 1, out_rdata = 0x8, out_exc = 0; csr_wvalid stays 0.
- WRITE 0x340 = 0xAA (id 3), then SET 0x340 wdata 0x05 (id 4) with no retire -> second out_rdata = 0xAA; queue holds 0xAA, 0xAF. Retire id 3 then id 4 -> csr_wdata 0xAA then 0xAF on consecutive retires.
- FWD_EN = 0: WRITE 0x340, then READ 0x340 -> in_ready = 0 until id retires; READ 0x341 accepted immediately.
- DEPTH = 4: fill with 4 writes -> in_ready = 0 for a WRITE. Same cycle retire of head -> 5th write accepted, count stays 4; 8 writes total exercise pointer wrap, all committed in order.
- cur_priv = 0, READ 0x300 -> out_exc = 1, out_rdata = 0, no enqueue. cur_priv = 3, WRITE 0xC00 -> out_exc = 1, no enqueue.
- 3 pending writes, flush asserted with retire of head id -> csr_wvalid = 1 for head only, count = 0 next cycle; a later retire of the other ids -> no csr_wvalid.
